// File: rtl/axi_pkg.sv
// Shared AXI4 definitions for the single-port AXI initiator: FSM states,
// protocol encodings and channel field widths.
package axi_pkg;

    localparam int unsigned AXI_ID_BITS    = 4;
    localparam int unsigned AXI_ADDR_BITS  = 32;
    localparam int unsigned AXI_DATA_BITS  = 32;
    localparam int unsigned AXI_STRB_BITS  = AXI_DATA_BITS / 8;
    localparam int unsigned AXI_LEN_BITS   = 4;
    localparam int unsigned AXI_SIZE_BITS  = 3;
    localparam int unsigned AXI_BURST_BITS = 2;
    localparam int unsigned AXI_RESP_BITS  = 2;

    localparam logic [AXI_RESP_BITS-1:0]  RESP_OKAY  = 2'b00;
    localparam logic [AXI_BURST_BITS-1:0] BURST_INCR = 2'b01;
    localparam logic [AXI_SIZE_BITS-1:0]  SIZE_WORD  = 3'b010;

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_AR   = 3'd1,
        S_R    = 3'd2,
        S_AW   = 3'd3,
        S_W    = 3'd4,
        S_B    = 3'd5
    } state_e;

endpackage : axi_pkg

// File: rtl/axi_master_if.sv
// AXI4 initiator: turns one request from a simple memory port into a single
// INCR read or write burst and reports read beats plus completion status.
module axi_master_if
    import axi_pkg::*;
#(
    parameter logic [AXI_ID_BITS-1:0] ID_VAL = 4'd0,
    parameter int unsigned            ADDR_W = AXI_ADDR_BITS,
    parameter int unsigned            DATA_W = AXI_DATA_BITS
) (
    input  logic                      clk,
    input  logic                      rst,

    input  logic                      req_valid,
    output logic                      req_ready,
    input  logic                      req_write,
    input  logic [ADDR_W-1:0]         req_addr,
    input  logic [AXI_LEN_BITS-1:0]   req_len,

    input  logic                      wd_valid,
    output logic                      wd_ready,
    input  logic [DATA_W-1:0]         wd_data,
    input  logic [DATA_W/8-1:0]       wd_strb,

    output logic                      rd_valid,
    output logic [DATA_W-1:0]         rd_data,
    output logic                      rd_last,
    output logic                      done,
    output logic                      err,

    output logic [AXI_ID_BITS-1:0]    AWID,
    output logic [ADDR_W-1:0]         AWADDR,
    output logic [AXI_LEN_BITS-1:0]   AWLEN,
    output logic [AXI_SIZE_BITS-1:0]  AWSIZE,
    output logic [AXI_BURST_BITS-1:0] AWBURST,
    output logic                      AWVALID,
    input  logic                      AWREADY,

    output logic [DATA_W-1:0]         WDATA,
    output logic [DATA_W/8-1:0]       WSTRB,
    output logic                      WLAST,
    output logic                      WVALID,
    input  logic                      WREADY,

    input  logic [AXI_ID_BITS-1:0]    BID,
    input  logic [AXI_RESP_BITS-1:0]  BRESP,
    input  logic                      BVALID,
    output logic                      BREADY,

    output logic [AXI_ID_BITS-1:0]    ARID,
    output logic [ADDR_W-1:0]         ARADDR,
    output logic [AXI_LEN_BITS-1:0]   ARLEN,
    output logic [AXI_SIZE_BITS-1:0]  ARSIZE,
    output logic [AXI_BURST_BITS-1:0] ARBURST,
    output logic                      ARVALID,
    input  logic                      ARREADY,

    input  logic [AXI_ID_BITS-1:0]    RID,
    input  logic [DATA_W-1:0]         RDATA,
    input  logic [AXI_RESP_BITS-1:0]  RRESP,
    input  logic                      RLAST,
    input  logic                      RVALID,
    output logic                      RREADY
);

    state_e                  state_q;
    logic [ADDR_W-1:0]       addr_q;
    logic [AXI_LEN_BITS-1:0] len_q;
    logic [AXI_LEN_BITS-1:0] cnt_q;
    logic                    rerr_q;

    logic r_beat_err;
    logic w_beat;
    logic w_last;

    // A read beat is bad on a bad response/ID, or when RLAST disagrees with the count.
    assign r_beat_err = (RRESP != RESP_OKAY) || (RID != ID_VAL) ||
                        (RLAST ? (cnt_q != len_q) : (cnt_q == len_q));
    assign w_beat     = wd_valid && WREADY;
    assign w_last     = (cnt_q == len_q);

    // Transaction FSM with latched request fields and the shared beat counter.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            addr_q  <= '0;
            len_q   <= '0;
            cnt_q   <= '0;
            rerr_q  <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (req_valid) begin
                        addr_q  <= req_addr;
                        len_q   <= req_len;
                        cnt_q   <= '0;
                        rerr_q  <= 1'b0;
                        state_q <= req_write ? S_AW : S_AR;
                    end
                end
                S_AR: begin
                    if (ARREADY) state_q <= S_R;
                end
                S_R: begin
                    if (RVALID) begin
                        rerr_q <= rerr_q | r_beat_err;
                        if (RLAST) begin
                            cnt_q   <= '0;
                            state_q <= S_IDLE;
                        end else begin
                            cnt_q <= cnt_q + 4'd1;
                        end
                    end
                end
                S_AW: begin
                    if (AWREADY) state_q <= S_W;
                end
                S_W: begin
                    if (w_beat) begin
                        if (w_last) begin
                            cnt_q   <= '0;
                            state_q <= S_B;
                        end else begin
                            cnt_q <= cnt_q + 4'd1;
                        end
                    end
                end
                S_B: begin
                    if (BVALID) state_q <= S_IDLE;
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    // Channel outputs decoded from the registered state; idle channels drive 0.
    always_comb begin
        req_ready = 1'b0;
        wd_ready  = 1'b0;
        rd_valid  = 1'b0;
        rd_data   = '0;
        rd_last   = 1'b0;
        done      = 1'b0;
        err       = 1'b0;
        AWID      = '0;
        AWADDR    = '0;
        AWLEN     = '0;
        AWSIZE    = '0;
        AWBURST   = '0;
        AWVALID   = 1'b0;
        WDATA     = '0;
        WSTRB     = '0;
        WLAST     = 1'b0;
        WVALID    = 1'b0;
        BREADY    = 1'b0;
        ARID      = '0;
        ARADDR    = '0;
        ARLEN     = '0;
        ARSIZE    = '0;
        ARBURST   = '0;
        ARVALID   = 1'b0;
        RREADY    = 1'b0;
        case (state_q)
            S_IDLE: req_ready = 1'b1;
            S_AR: begin
                ARVALID = 1'b1;
                ARID    = ID_VAL;
                ARADDR  = addr_q;
                ARLEN   = len_q;
                ARSIZE  = SIZE_WORD;
                ARBURST = BURST_INCR;
            end
            S_R: begin
                RREADY   = 1'b1;
                rd_valid = RVALID;
                rd_data  = RVALID ? RDATA : '0;
                rd_last  = RVALID && RLAST;
                done     = RVALID && RLAST;
                err      = RVALID && RLAST && (rerr_q || r_beat_err);
            end
            S_AW: begin
                AWVALID = 1'b1;
                AWID    = ID_VAL;
                AWADDR  = addr_q;
                AWLEN   = len_q;
                AWSIZE  = SIZE_WORD;
                AWBURST = BURST_INCR;
            end
            S_W: begin
                WVALID   = wd_valid;
                WDATA    = wd_data;
                WSTRB    = wd_strb;
                WLAST    = w_last;
                wd_ready = WREADY;
            end
            S_B: begin
                BREADY = 1'b1;
                done   = BVALID;
                err    = BVALID && ((BRESP != RESP_OKAY) || (BID != ID_VAL));
            end
            default: ;
        endcase
    end

endmodule : axi_master_if

// File: tb/tb_axi_master_if.sv
// Self-checking bench for axi_master_if: a scripted AXI slave drives each
// channel cycle by cycle while expected beats flow through scoreboard queues.
module tb_axi_master_if;
    import axi_pkg::*;

    localparam logic [3:0] TB_ID = 4'd0;

    logic        clk, rst;
    logic        req_valid, req_ready, req_write;
    logic [31:0] req_addr;
    logic [3:0]  req_len;
    logic        wd_valid, wd_ready;
    logic [31:0] wd_data;
    logic [3:0]  wd_strb;
    logic        rd_valid, rd_last, done, err;
    logic [31:0] rd_data;
    logic [3:0]  AWID, AWLEN, ARID, ARLEN, BID, RID;
    logic [31:0] AWADDR, ARADDR, WDATA, RDATA;
    logic [2:0]  AWSIZE, ARSIZE;
    logic [1:0]  AWBURST, ARBURST, BRESP, RRESP;
    logic        AWVALID, AWREADY, WLAST, WVALID, WREADY, BVALID, BREADY;
    logic        ARVALID, ARREADY, RLAST, RVALID, RREADY;
    logic [3:0]  WSTRB;

    int errors = 0;
    int checks = 0;
    logic [31:0] exp_rd_q[$];
    logic [35:0] exp_wd_q[$];

    axi_master_if #(.ID_VAL(TB_ID), .ADDR_W(32), .DATA_W(32)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
        .req_addr(req_addr), .req_len(req_len),
        .wd_valid(wd_valid), .wd_ready(wd_ready), .wd_data(wd_data), .wd_strb(wd_strb),
        .rd_valid(rd_valid), .rd_data(rd_data), .rd_last(rd_last), .done(done), .err(err),
        .AWID(AWID), .AWADDR(AWADDR), .AWLEN(AWLEN), .AWSIZE(AWSIZE), .AWBURST(AWBURST),
        .AWVALID(AWVALID), .AWREADY(AWREADY),
        .WDATA(WDATA), .WSTRB(WSTRB), .WLAST(WLAST), .WVALID(WVALID), .WREADY(WREADY),
        .BID(BID), .BRESP(BRESP), .BVALID(BVALID), .BREADY(BREADY),
        .ARID(ARID), .ARADDR(ARADDR), .ARLEN(ARLEN), .ARSIZE(ARSIZE), .ARBURST(ARBURST),
        .ARVALID(ARVALID), .ARREADY(ARREADY),
        .RID(RID), .RDATA(RDATA), .RRESP(RRESP), .RLAST(RLAST), .RVALID(RVALID), .RREADY(RREADY)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic issue_req(input logic wr, input logic [31:0] a, input logic [3:0] l, input bit hold);
        req_valid = 1'b1; req_write = wr; req_addr = a; req_len = l;
        @(negedge clk);
        checks++;
        if (req_ready !== 1'b1) begin
            errors++; $display("FAIL req_accept: got req_ready=%b want 1", req_ready);
        end
        tick();
        if (!hold) req_valid = 1'b0;
    endtask

    task automatic ar_phase(input logic [31:0] a, input logic [3:0] l, input int delay);
        for (int k = 0; k <= delay; k++) begin
            ARREADY = (k == delay);
            @(negedge clk);
            checks++;
            if ({ARVALID, ARADDR, ARLEN, ARSIZE, ARBURST, ARID} !== {1'b1, a, l, SIZE_WORD, BURST_INCR, TB_ID}) begin
                errors++;
                $display("FAIL ar_fields: got %h want %h", {ARVALID, ARADDR, ARLEN, ARSIZE, ARBURST, ARID},
                         {1'b1, a, l, SIZE_WORD, BURST_INCR, TB_ID});
            end
            checks++;
            if ({AWVALID, BREADY, RREADY, req_ready} !== 4'b0000) begin
                errors++; $display("FAIL ar_exclusive: got aw/b/r/req=%b want 0000", {AWVALID, BREADY, RREADY, req_ready});
            end
            tick();
        end
        ARREADY = 1'b0;
    endtask

    task automatic r_phase(input int n_beats, input logic [31:0] base, input logic [31:0] gaps,
                           input int err_beat, input logic exp_err);
        int pulses;
        logic [31:0] e;
        pulses = 0;
        for (int i = 0; i < n_beats; i++) begin
            for (int g = 0; g < int'(gaps[2*i +: 2]); g++) begin
                RVALID = 1'b0;
                @(negedge clk);
                checks++;
                if ({rd_valid, done, RREADY} !== 3'b001) begin
                    errors++; $display("FAIL r_gap: got rd_valid/done/RREADY=%b want 001", {rd_valid, done, RREADY});
                end
                tick();
            end
            RVALID = 1'b1;
            RDATA  = base + 32'(i) * 32'h0101_0101;
            RLAST  = (i == n_beats - 1);
            RRESP  = (i == err_beat) ? 2'b10 : 2'b00;
            RID    = TB_ID;
            exp_rd_q.push_back(RDATA);
            @(negedge clk);
            if (rd_valid) begin
                pulses++;
                checks++;
                e = (exp_rd_q.size() != 0) ? exp_rd_q.pop_front() : 32'hxxxx_xxxx;
                if (rd_data !== e) begin
                    errors++; $display("FAIL rd_data beat %0d: got %h want %h", i, rd_data, e);
                end
            end
            checks++;
            if ({rd_last, done} !== {RLAST, RLAST}) begin
                errors++; $display("FAIL r_last_done beat %0d: got %b want %b", i, {rd_last, done}, {RLAST, RLAST});
            end
            if (RLAST) begin
                checks++;
                if (err !== exp_err) begin
                    errors++; $display("FAIL r_err: got %b want %b", err, exp_err);
                end
            end
            tick();
        end
        RVALID = 1'b0; RLAST = 1'b0; RRESP = 2'b00;
        checks++;
        if (pulses != n_beats || exp_rd_q.size() != 0) begin
            errors++; $display("FAIL rd_pulses: got %0d want %0d", pulses, n_beats);
        end
        exp_rd_q.delete();
        @(negedge clk);
        checks++;
        if ({req_ready, done, rd_valid} !== 3'b100) begin
            errors++; $display("FAIL r_return_idle: got req_ready/done/rd_valid=%b want 100", {req_ready, done, rd_valid});
        end
        tick();
    endtask

    task automatic aw_phase(input logic [31:0] a, input logic [3:0] l, input int delay);
        WREADY = 1'b1;
        for (int k = 0; k <= delay; k++) begin
            AWREADY = (k == delay);
            @(negedge clk);
            checks++;
            if ({AWVALID, AWADDR, AWLEN, AWSIZE, AWBURST, AWID} !== {1'b1, a, l, SIZE_WORD, BURST_INCR, TB_ID}) begin
                errors++;
                $display("FAIL aw_fields: got %h want %h", {AWVALID, AWADDR, AWLEN, AWSIZE, AWBURST, AWID},
                         {1'b1, a, l, SIZE_WORD, BURST_INCR, TB_ID});
            end
            checks++;
            if ({ARVALID, WVALID, wd_ready, req_ready} !== 4'b0000) begin
                errors++; $display("FAIL aw_exclusive: got ar/w/wd_ready/req=%b want 0000", {ARVALID, WVALID, wd_ready, req_ready});
            end
            tick();
        end
        AWREADY = 1'b0;
        WREADY  = 1'b0;
    endtask

    task automatic w_phase(input logic [3:0] l, input int stall_beat, input int stall_cycles);
        logic [35:0] e;
        for (int i = 0; i <= int'(l); i++) begin
            if (i % 2 == 1) begin
                wd_valid = 1'b0; WREADY = 1'b1;
                @(negedge clk);
                checks++;
                if ({WVALID, wd_ready} !== 2'b01) begin
                    errors++; $display("FAIL w_idle: got WVALID/wd_ready=%b want 01", {WVALID, wd_ready});
                end
                tick();
            end
            wd_valid = 1'b1;
            wd_data  = $urandom;
            wd_strb  = 4'($urandom);
            exp_wd_q.push_back({wd_strb, wd_data});
            for (int s = 0; s < ((i == stall_beat) ? stall_cycles : 0); s++) begin
                WREADY = 1'b0;
                @(negedge clk);
                checks++;
                if ({WVALID, wd_ready, WLAST, WDATA} !== {1'b1, 1'b0, (i == int'(l)), wd_data}) begin
                    errors++; $display("FAIL w_stall beat %0d: got %b %b %b %h", i, WVALID, wd_ready, WLAST, WDATA);
                end
                tick();
            end
            WREADY = 1'b1;
            @(negedge clk);
            checks++;
            if ({WVALID, wd_ready, WLAST} !== {1'b1, 1'b1, (i == int'(l))}) begin
                errors++; $display("FAIL w_ctrl beat %0d: got %b want %b", i, {WVALID, wd_ready, WLAST},
                                   {1'b1, 1'b1, (i == int'(l))});
            end
            e = (exp_wd_q.size() != 0) ? exp_wd_q.pop_front() : 36'hx_xxxx_xxxx;
            checks++;
            if ({WSTRB, WDATA} !== e) begin
                errors++; $display("FAIL w_data beat %0d: got %h want %h", i, {WSTRB, WDATA}, e);
            end
            tick();
        end
        wd_valid = 1'b0; WREADY = 1'b0;
    endtask

    task automatic b_phase(input int delay, input logic [1:0] bresp, input logic exp_err);
        for (int k = 0; k <= delay; k++) begin
            BVALID = (k == delay); BRESP = bresp; BID = TB_ID;
            @(negedge clk);
            checks++;
            if ({BREADY, done, ARVALID, AWVALID, WVALID} !== {1'b1, (k == delay), 3'b000}) begin
                errors++; $display("FAIL b_ctrl: got %b want %b", {BREADY, done, ARVALID, AWVALID, WVALID},
                                   {1'b1, (k == delay), 3'b000});
            end
            if (k == delay) begin
                checks++;
                if (err !== exp_err) begin
                    errors++; $display("FAIL b_err: got %b want %b", err, exp_err);
                end
            end
            tick();
        end
        BVALID = 1'b0; BRESP = 2'b00;
        @(negedge clk);
        checks++;
        if ({req_ready, done} !== 2'b10) begin
            errors++; $display("FAIL b_return_idle: got req_ready/done=%b want 10", {req_ready, done});
        end
        tick();
    endtask

    task automatic test_reset();
        rst = 1'b1; RVALID = 1'b1; RLAST = 1'b1; WREADY = 1'b1; BVALID = 1'b1;
        tick(); tick();
        @(negedge clk);
        checks++;
        if ({ARVALID, AWVALID, WVALID, RREADY, BREADY, done, err, rd_valid, wd_ready} !== 9'b0) begin
            errors++; $display("FAIL reset_outputs: got %b want 0", {ARVALID, AWVALID, WVALID, RREADY, BREADY,
                                                                      done, err, rd_valid, wd_ready});
        end
        checks++;
        if (req_ready !== 1'b1) begin
            errors++; $display("FAIL reset_idle: got req_ready=%b want 1", req_ready);
        end
        RVALID = 1'b0; RLAST = 1'b0; WREADY = 1'b0; BVALID = 1'b0;
        tick();
        rst = 1'b0;
        tick();
    endtask

    task automatic test_single_read();
        issue_req(1'b0, 32'h0000_0010, 4'd0, 1'b0);
        ar_phase(32'h0000_0010, 4'd0, 3);
        r_phase(1, 32'hDEAD_BEEF, 32'h0, -1, 1'b0);
    endtask

    task automatic test_burst_read();
        issue_req(1'b0, 32'h0000_1000, 4'd3, 1'b0);
        ar_phase(32'h0000_1000, 4'd3, 1);
        r_phase(4, 32'h1122_3344, 32'h0000_0090, -1, 1'b0);
    endtask

    task automatic test_burst_write();
        issue_req(1'b1, 32'h0000_2000, 4'd3, 1'b0);
        aw_phase(32'h0000_2000, 4'd3, 1);
        w_phase(4'd3, 1, 2);
        b_phase(2, 2'b00, 1'b0);
    endtask

    task automatic test_errors();
        issue_req(1'b0, 32'h0000_3000, 4'd1, 1'b0);
        ar_phase(32'h0000_3000, 4'd1, 0);
        r_phase(2, 32'hA5A5_0000, 32'h0, 0, 1'b1);
        issue_req(1'b1, 32'h0000_3100, 4'd0, 1'b0);
        aw_phase(32'h0000_3100, 4'd0, 0);
        w_phase(4'd0, -1, 0);
        b_phase(0, 2'b11, 1'b1);
        issue_req(1'b0, 32'h0000_3200, 4'd3, 1'b0);
        ar_phase(32'h0000_3200, 4'd3, 0);
        r_phase(2, 32'h5A5A_0000, 32'h0000_0004, -1, 1'b1);
    endtask

    task automatic test_reset_mid_burst();
        logic [35:0] e;
        issue_req(1'b1, 32'h0000_0040, 4'd3, 1'b0);
        aw_phase(32'h0000_0040, 4'd3, 0);
        wd_valid = 1'b1; WREADY = 1'b1; wd_data = 32'hCAFE_0001; wd_strb = 4'hF;
        exp_wd_q.push_back({wd_strb, wd_data});
        @(negedge clk);
        e = exp_wd_q.pop_front();
        checks++;
        if ({WSTRB, WDATA} !== e) begin
            errors++; $display("FAIL rst_w_beat: got %h want %h", {WSTRB, WDATA}, e);
        end
        tick();
        rst = 1'b1; wd_data = 32'hCAFE_0002;
        tick();
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if ({AWVALID, WVALID, ARVALID, BREADY, RREADY, done, wd_ready, req_ready} !== 8'b0000_0001) begin
            errors++; $display("FAIL rst_mid_burst: got %b want 00000001", {AWVALID, WVALID, ARVALID, BREADY,
                                                                              RREADY, done, wd_ready, req_ready});
        end
        tick();
        wd_valid = 1'b0; WREADY = 1'b0;
        exp_wd_q.delete();
        issue_req(1'b0, 32'h0000_0080, 4'd1, 1'b0);
        ar_phase(32'h0000_0080, 4'd1, 0);
        r_phase(2, 32'h0BAD_F00D, 32'h0, -1, 1'b0);
    endtask

    task automatic test_back_to_back();
        issue_req(1'b1, 32'h0000_0100, 4'd0, 1'b1);
        aw_phase(32'h0000_0100, 4'd0, 0);
        w_phase(4'd0, -1, 0);
        req_write = 1'b0; req_addr = 32'h0000_0200; req_len = 4'd1;
        b_phase(1, 2'b00, 1'b0);
        req_valid = 1'b0;
        ar_phase(32'h0000_0200, 4'd1, 0);
        r_phase(2, 32'h1357_9BDF, 32'h0000_0004, -1, 1'b0);
    endtask

    initial begin
        rst = 1'b1; req_valid = 1'b0; req_write = 1'b0; req_addr = '0; req_len = '0;
        wd_valid = 1'b0; wd_data = '0; wd_strb = '0;
        AWREADY = 1'b0; WREADY = 1'b0; BID = '0; BRESP = '0; BVALID = 1'b0;
        ARREADY = 1'b0; RID = '0; RDATA = '0; RRESP = '0; RLAST = 1'b0; RVALID = 1'b0;
        test_reset();
        test_single_read();
        test_burst_read();
        test_burst_write();
        test_errors();
        test_reset_mid_burst();
        test_back_to_back();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule : tb_axi_master_if
